memory_unit: RTL and testbench

Unified instruction/data memory that serves as the responder for the processor's memory interface. It returns instruction words on the fetch port, answers data reads combinationally and commits stores on the clock edge. After reset it clears the whole array with a sequential sweep, then accepts a program image over a valid/ready loader port, and only then enters service mode. It sits beside `processor` at the top level; the top level holds the processor in reset until `mem_ready` is high.

---
 rtl/memory_unit.sv | 150 +++++++++++++++
 tb/tb_memory_unit.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/memory_unit.sv
// memory_unit: unified instruction/data memory responding to the processor.
// After reset it zeroes the whole array, then accepts a program image over a
// valid/ready loader port, then serves fetches, data reads and stores.
//
// Ports:
//   clk, reset           clock, synchronous active-high reset
//   addr / instruction   fetch byte address / fetched word (combinational)
//   read_addr2 / read_data2   data read byte address / data (combinational)
//   write_addr, write_data, mem_write_enable   store port (commits on edge)
//   load_valid, load_data, load_last, load_ready   program image loader
//   mem_ready            high once the image is loaded (service mode)
//   fault                sticky out-of-range access flag
//
// state    | meaning
// ---------+------------------------------------------------------------
// ST_CLEAR | sweeping ptr over the array, writing zeros
// ST_LOAD  | accepting loader words at ptr
// ST_RUN   | serving fetch/read/store traffic; terminal until reset

module memory_unit #(
   parameter int DEPTH  = 256,
   parameter int ADDR_W = 8
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] addr,
   output logic [31:0] instruction,
   input  logic [31:0] read_addr2,
   output logic [31:0] read_data2,
   input  logic [31:0] write_addr,
   input  logic [31:0] write_data,
   input  logic        mem_write_enable,
   input  logic        load_valid,
   input  logic [31:0] load_data,
   input  logic        load_last,
   output logic        load_ready,
   output logic        mem_ready,
   output logic        fault
);

   typedef enum logic [1:0] {
      ST_CLEAR,
      ST_LOAD,
      ST_RUN
   } state_t;

   localparam logic [ADDR_W:0] PTR_LAST = (ADDR_W+1)'(DEPTH-1);

   state_t            state_q, state_d;
   logic [ADDR_W:0]   ptr_q, ptr_d;
   logic              fault_q, fault_d;
   logic [31:0]       mem_q [DEPTH];

   logic              wr_en;
   logic [ADDR_W-1:0] wr_idx;
   logic [31:0]       wr_data;

   logic              fetch_in_range, rd2_in_range, st_in_range;
   logic [ADDR_W-1:0] fetch_idx, rd2_idx, st_idx;

   // Byte-offset bits never select anything and never fault.
   logic              unused_byte_bits;
   assign unused_byte_bits = ^{addr[1:0], read_addr2[1:0], write_addr[1:0]};

   assign fetch_idx      = addr[ADDR_W+1:2];
   assign rd2_idx        = read_addr2[ADDR_W+1:2];
   assign st_idx         = write_addr[ADDR_W+1:2];
   assign fetch_in_range = (addr[31:ADDR_W+2] == '0);
   assign rd2_in_range   = (read_addr2[31:ADDR_W+2] == '0);
   assign st_in_range    = (write_addr[31:ADDR_W+2] == '0);

   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      fault_d = fault_q;
      wr_en   = 1'b0;
      wr_idx  = ptr_q[ADDR_W-1:0];
      wr_data = '0;
      case (state_q)
         ST_CLEAR: begin
            wr_en = 1'b1;
            ptr_d = ptr_q + 1'b1;
            if (ptr_q == PTR_LAST) begin
               state_d = ST_LOAD;
               ptr_d   = '0;
            end
         end
         ST_LOAD: begin
            if (load_valid) begin
               wr_en   = 1'b1;
               wr_data = load_data;
               ptr_d   = ptr_q + 1'b1;
               // A full array ends the load even without load_last.
               if (load_last || (ptr_q == PTR_LAST)) begin
                  state_d = ST_RUN;
               end
            end
         end
         ST_RUN: begin
            if (mem_write_enable) begin
               if (st_in_range) begin
                  wr_en   = 1'b1;
                  wr_idx  = st_idx;
                  wr_data = write_data;
               end else begin
                  fault_d = 1'b1;
               end
            end
            if (!fetch_in_range) begin
               fault_d = 1'b1;
            end
            // The data read address is undriven during stores, so only
            // check it when no store is requested.
            if (!mem_write_enable && !rd2_in_range) begin
               fault_d = 1'b1;
            end
         end
         default: begin
            state_d = ST_CLEAR;
            ptr_d   = '0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= ST_CLEAR;
         ptr_q   <= '0;
         fault_q <= 1'b0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         fault_q <= fault_d;
      end
   end

   always_ff @(posedge clk) begin
      if (wr_en && !reset) begin
         mem_q[wr_idx] <= wr_data;
      end
   end

   // Reads see the pre-edge contents, so a same-cycle store is not visible.
   assign instruction = (state_q == ST_RUN && fetch_in_range) ? mem_q[fetch_idx] : '0;
   assign read_data2  = (state_q == ST_RUN && rd2_in_range)   ? mem_q[rd2_idx]   : '0;
   assign load_ready  = (state_q == ST_LOAD);
   assign mem_ready   = (state_q == ST_RUN);
   assign fault       = fault_q;

endmodule

// File: tb/tb_memory_unit.sv
module tb_memory_unit;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [31:0] addr = '0;
   logic [31:0] instruction;
   logic [31:0] read_addr2 = '0;
   logic [31:0] read_data2;
   logic [31:0] write_addr = '0;
   logic [31:0] write_data = '0;
   logic        mem_write_enable = 1'b0;
   logic        load_valid = 1'b0;
   logic [31:0] load_data = '0;
   logic        load_last = 1'b0;
   logic        load_ready;
   logic        mem_ready;
   logic        fault;

   int checks = 0;
   int failures = 0;

   memory_unit #(.DEPTH(256), .ADDR_W(8)) dut (
      .clk              (clk),
      .reset            (reset),
      .addr             (addr),
      .instruction      (instruction),
      .read_addr2       (read_addr2),
      .read_data2       (read_data2),
      .write_addr       (write_addr),
      .write_data       (write_data),
      .mem_write_enable (mem_write_enable),
      .load_valid       (load_valid),
      .load_data        (load_data),
      .load_last        (load_last),
      .load_ready       (load_ready),
      .mem_ready        (mem_ready),
      .fault            (fault)
   );

   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   // Ends just after a negedge with reset low; n edges saw reset high.
   task automatic apply_reset(input int n);
      @(negedge clk);
      reset = 1'b1;
      repeat (n) @(negedge clk);
      reset = 1'b0;
      #1;
      check_eq("rst_load_ready", {31'd0, load_ready}, 32'd0);
      check_eq("rst_mem_ready", {31'd0, mem_ready}, 32'd0);
      check_eq("rst_fault", {31'd0, fault}, 32'd0);
      check_eq("rst_instruction", instruction, 32'd0);
      check_eq("rst_read_data2", read_data2, 32'd0);
   endtask

   // load_ready must stay low for post-reset edges 1..255 and rise at 256.
   task automatic run_sweep;
      for (int c = 1; c <= 256; c++) begin
         @(negedge clk);
         #1;
         check_eq("sweep_load_ready", {31'd0, load_ready}, (c == 256) ? 32'd1 : 32'd0);
         check_eq("sweep_mem_ready", {31'd0, mem_ready}, 32'd0);
      end
   endtask

   task automatic load_word(input logic [31:0] d, input logic last);
      load_valid = 1'b1;
      load_data  = d;
      load_last  = last;
      @(negedge clk);
      load_valid = 1'b0;
      load_last  = 1'b0;
      #1;
   endtask

   task automatic fetch_expect(input string tag, input logic [31:0] a, input logic [31:0] exp);
      addr = a;
      #1;
      check_eq(tag, instruction, exp);
   endtask

   initial begin
      // Reset for 2 cycles, then idle through the clear sweep.
      apply_reset(2);
      run_sweep();

      // Three-word program image.
      load_word(32'hE3A01005, 1'b0);
      check_eq("load_mem_ready_w1", {31'd0, mem_ready}, 32'd0);
      load_word(32'hE2811001, 1'b0);
      check_eq("load_mem_ready_w2", {31'd0, mem_ready}, 32'd0);
      load_word(32'hEAFFFFFE, 1'b1);
      check_eq("load_mem_ready_after", {31'd0, mem_ready}, 32'd1);
      check_eq("load_ready_after", {31'd0, load_ready}, 32'd0);

      fetch_expect("fetch_0x0", 32'h0, 32'hE3A01005);
      fetch_expect("fetch_0x4", 32'h4, 32'hE2811001);
      fetch_expect("fetch_0x8", 32'h8, 32'hEAFFFFFE);
      fetch_expect("fetch_0x6", 32'h6, 32'hE2811001);
      fetch_expect("fetch_0xC", 32'hC, 32'h0);
      read_addr2 = 32'h8;
      #1;
      check_eq("read2_0x8", read_data2, 32'hEAFFFFFE);
      check_eq("fault_clean", {31'd0, fault}, 32'd0);

      // Store with same-cycle read: old value now, new value next cycle.
      @(negedge clk);
      addr             = 32'h0;
      mem_write_enable = 1'b1;
      write_addr       = 32'h10;
      write_data       = 32'hDEADBEEF;
      read_addr2       = 32'h10;
      #1;
      check_eq("store_same_cycle", read_data2, 32'h0);
      @(negedge clk);
      mem_write_enable = 1'b0;
      #1;
      check_eq("store_next_cycle", read_data2, 32'hDEADBEEF);
      check_eq("store_no_fault", {31'd0, fault}, 32'd0);

      // Out-of-range store: dropped, fault from the next cycle.
      @(negedge clk);
      mem_write_enable = 1'b1;
      write_addr       = 32'h400;
      write_data       = 32'h12345678;
      read_addr2       = 32'h400;
      #1;
      check_eq("oor_read2", read_data2, 32'h0);
      check_eq("oor_fault_same", {31'd0, fault}, 32'd0);
      @(negedge clk);
      mem_write_enable = 1'b0;
      read_addr2       = 32'h0;
      #1;
      check_eq("oor_fault_next", {31'd0, fault}, 32'd1);
      fetch_expect("oor_no_write", 32'h0, 32'hE3A01005);

      // Full 256-word stream without load_last, then a 257th word.
      apply_reset(1);
      run_sweep();
      for (int i = 0; i < 256; i++) begin
         check_eq("stream_mem_ready_pre", {31'd0, mem_ready}, 32'd0);
         load_word(32'h1000_0000 + 32'(i), 1'b0);
      end
      check_eq("stream_mem_ready", {31'd0, mem_ready}, 32'd1);
      load_word(32'h0000_0BAD, 1'b0);
      fetch_expect("stream_last_idx", 32'h3FC, 32'h1000_00FF);
      fetch_expect("stream_idx0", 32'h0, 32'h1000_0000);
      fetch_expect("stream_idx1", 32'h4, 32'h1000_0001);

      // Out-of-range fetch sets fault, then reset must clear it.
      @(negedge clk);
      addr = 32'h800;
      @(negedge clk);
      addr = 32'h0;
      #1;
      check_eq("fetch_oor_fault", {31'd0, fault}, 32'd1);
      apply_reset(1);

      // Partial load interrupted by reset, then a single-word reload.
      run_sweep();
      load_word(32'hAAAA_0001, 1'b0);
      load_word(32'hAAAA_0002, 1'b0);
      check_eq("partial_mem_ready", {31'd0, mem_ready}, 32'd0);
      apply_reset(1);
      run_sweep();
      load_word(32'h0000_0055, 1'b1);
      check_eq("reload_mem_ready", {31'd0, mem_ready}, 32'd1);
      fetch_expect("reload_idx0", 32'h0, 32'h0000_0055);
      fetch_expect("reload_idx1", 32'h4, 32'h0);
      check_eq("reload_fault", {31'd0, fault}, 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
